// File: rtl/axil_rr_master.sv
// Two-client round-robin AXI-Lite master: serialises single-beat read/write
// commands onto one AXI-Lite port and routes each response to its issuer.
module axil_rr_master #(
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                          aclk,
  input  logic                          aresetn,
  input  logic [1:0]                    req_valid,
  output logic [1:0]                    req_ready,
  input  logic [1:0]                    req_write,
  input  logic [2*ADDR_WIDTH-1:0]       req_addr,
  input  logic [2*DATA_WIDTH-1:0]       req_wdata,
  input  logic [2*(DATA_WIDTH/8)-1:0]   req_wstrb,
  output logic [1:0]                    rsp_valid,
  output logic [DATA_WIDTH-1:0]         rsp_rdata,
  output logic [1:0]                    rsp_resp,
  output logic [ADDR_WIDTH-1:0]         m_axi_awaddr,
  output logic                          m_axi_awvalid,
  input  logic                          m_axi_awready,
  output logic [DATA_WIDTH-1:0]         m_axi_wdata,
  output logic [DATA_WIDTH/8-1:0]       m_axi_wstrb,
  output logic                          m_axi_wvalid,
  input  logic                          m_axi_wready,
  input  logic [1:0]                    m_axi_bresp,
  input  logic                          m_axi_bvalid,
  output logic                          m_axi_bready,
  output logic [ADDR_WIDTH-1:0]         m_axi_araddr,
  output logic                          m_axi_arvalid,
  input  logic                          m_axi_arready,
  input  logic [DATA_WIDTH-1:0]         m_axi_rdata,
  input  logic [1:0]                    m_axi_rresp,
  input  logic                          m_axi_rvalid,
  output logic                          m_axi_rready
);

  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_REQ,
    S_WR_RESP,
    S_RD_REQ,
    S_RD_RESP,
    S_DONE
  } state_t;

  state_t                  r_state,      w_state_nxt;
  logic                    r_last_grant, w_last_grant_nxt;
  logic                    r_grant,      w_grant_nxt;
  logic [ADDR_WIDTH-1:0]   r_addr,       w_addr_nxt;
  logic [DATA_WIDTH-1:0]   r_wdata,      w_wdata_nxt;
  logic [STRB_WIDTH-1:0]   r_wstrb,      w_wstrb_nxt;
  logic [1:0]              r_req_ready,  w_req_ready_nxt;
  logic [1:0]              r_rsp_valid,  w_rsp_valid_nxt;
  logic [DATA_WIDTH-1:0]   r_rsp_rdata,  w_rsp_rdata_nxt;
  logic [1:0]              r_rsp_resp,   w_rsp_resp_nxt;
  logic                    r_awvalid,    w_awvalid_nxt;
  logic                    r_wvalid,     w_wvalid_nxt;
  logic                    r_bready,     w_bready_nxt;
  logic                    r_arvalid,    w_arvalid_nxt;
  logic                    r_rready,     w_rready_nxt;

  logic                    w_sel;
  logic                    w_sel_write;
  logic                    w_aw_done;
  logic                    w_w_done;
  logic [1:0]              w_grant_onehot;

  // Tie goes to the client that was not served last
  assign w_sel          = (&req_valid) ? ~r_last_grant : req_valid[1];
  assign w_sel_write    = w_sel ? req_write[1] : req_write[0];
  assign w_aw_done      = !r_awvalid || m_axi_awready;
  assign w_w_done       = !r_wvalid  || m_axi_wready;
  assign w_grant_onehot = r_grant ? 2'b10 : 2'b01;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state      <= S_IDLE;
      r_last_grant <= 1'b1;
      r_grant      <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_wstrb      <= '0;
      r_req_ready  <= '0;
      r_rsp_valid  <= '0;
      r_rsp_rdata  <= '0;
      r_rsp_resp   <= '0;
      r_awvalid    <= 1'b0;
      r_wvalid     <= 1'b0;
      r_bready     <= 1'b0;
      r_arvalid    <= 1'b0;
      r_rready     <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_last_grant <= w_last_grant_nxt;
      r_grant      <= w_grant_nxt;
      r_addr       <= w_addr_nxt;
      r_wdata      <= w_wdata_nxt;
      r_wstrb      <= w_wstrb_nxt;
      r_req_ready  <= w_req_ready_nxt;
      r_rsp_valid  <= w_rsp_valid_nxt;
      r_rsp_rdata  <= w_rsp_rdata_nxt;
      r_rsp_resp   <= w_rsp_resp_nxt;
      r_awvalid    <= w_awvalid_nxt;
      r_wvalid     <= w_wvalid_nxt;
      r_bready     <= w_bready_nxt;
      r_arvalid    <= w_arvalid_nxt;
      r_rready     <= w_rready_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_last_grant_nxt = r_last_grant;
    w_grant_nxt      = r_grant;
    w_addr_nxt       = r_addr;
    w_wdata_nxt      = r_wdata;
    w_wstrb_nxt      = r_wstrb;
    w_req_ready_nxt  = 2'b00;
    w_rsp_valid_nxt  = 2'b00;
    w_rsp_rdata_nxt  = r_rsp_rdata;
    w_rsp_resp_nxt   = r_rsp_resp;
    w_awvalid_nxt    = r_awvalid;
    w_wvalid_nxt     = r_wvalid;
    w_bready_nxt     = r_bready;
    w_arvalid_nxt    = r_arvalid;
    w_rready_nxt     = r_rready;

    case (r_state)
      S_IDLE: begin
        if (|req_valid) begin
          w_grant_nxt      = w_sel;
          w_last_grant_nxt = w_sel;
          w_req_ready_nxt  = w_sel ? 2'b10 : 2'b01;
          w_addr_nxt  = w_sel ? req_addr[2*ADDR_WIDTH-1:ADDR_WIDTH] : req_addr[ADDR_WIDTH-1:0];
          w_wdata_nxt = w_sel ? req_wdata[2*DATA_WIDTH-1:DATA_WIDTH] : req_wdata[DATA_WIDTH-1:0];
          w_wstrb_nxt = w_sel ? req_wstrb[2*STRB_WIDTH-1:STRB_WIDTH] : req_wstrb[STRB_WIDTH-1:0];
          if (w_sel_write) begin
            w_awvalid_nxt = 1'b1;
            w_wvalid_nxt  = 1'b1;
            w_state_nxt   = S_WR_REQ;
          end else begin
            w_arvalid_nxt = 1'b1;
            w_state_nxt   = S_RD_REQ;
          end
        end
      end
      S_WR_REQ: begin
        // AW and W retire independently, in either order
        if (r_awvalid && m_axi_awready) w_awvalid_nxt = 1'b0;
        if (r_wvalid && m_axi_wready)   w_wvalid_nxt  = 1'b0;
        if (w_aw_done && w_w_done) begin
          w_bready_nxt = 1'b1;
          w_state_nxt  = S_WR_RESP;
        end
      end
      S_WR_RESP: begin
        if (m_axi_bvalid) begin
          w_bready_nxt    = 1'b0;
          w_rsp_valid_nxt = w_grant_onehot;
          w_rsp_rdata_nxt = '0;
          w_rsp_resp_nxt  = m_axi_bresp;
          w_state_nxt     = S_DONE;
        end
      end
      S_RD_REQ: begin
        if (m_axi_arready) begin
          w_arvalid_nxt = 1'b0;
          w_rready_nxt  = 1'b1;
          w_state_nxt   = S_RD_RESP;
        end
      end
      S_RD_RESP: begin
        if (m_axi_rvalid) begin
          w_rready_nxt    = 1'b0;
          w_rsp_valid_nxt = w_grant_onehot;
          w_rsp_rdata_nxt = m_axi_rdata;
          w_rsp_resp_nxt  = m_axi_rresp;
          w_state_nxt     = S_DONE;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign req_ready     = r_req_ready;
  assign rsp_valid     = r_rsp_valid;
  assign rsp_rdata     = r_rsp_rdata;
  assign rsp_resp      = r_rsp_resp;
  assign m_axi_awaddr  = r_addr;
  assign m_axi_awvalid = r_awvalid;
  assign m_axi_wdata   = r_wdata;
  assign m_axi_wstrb   = r_wstrb;
  assign m_axi_wvalid  = r_wvalid;
  assign m_axi_bready  = r_bready;
  assign m_axi_araddr  = r_addr;
  assign m_axi_arvalid = r_arvalid;
  assign m_axi_rready  = r_rready;

endmodule

// File: tb/tb_axil_rr_master.sv
// Bench for axil_rr_master: stallable 4-register AXI-Lite slave, a
// transaction-level reference model and directed plus randomized traffic.
module tb_axil_rr_master;

  localparam int unsigned AW = 4;
  localparam int unsigned DW = 32;
  localparam int unsigned SW = DW / 8;

  logic              aclk = 1'b0;
  logic              aresetn;
  logic [1:0]        req_valid, req_ready, req_write, rsp_valid, rsp_resp;
  logic [2*AW-1:0]   req_addr;
  logic [2*DW-1:0]   req_wdata;
  logic [2*SW-1:0]   req_wstrb;
  logic [DW-1:0]     rsp_rdata;
  logic [AW-1:0]     m_axi_awaddr, m_axi_araddr;
  logic              m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready;
  logic [DW-1:0]     m_axi_wdata, m_axi_rdata;
  logic [SW-1:0]     m_axi_wstrb;
  logic [1:0]        m_axi_bresp, m_axi_rresp;
  logic              m_axi_bvalid, m_axi_bready, m_axi_arvalid, m_axi_arready;
  logic              m_axi_rvalid, m_axi_rready;

  axil_rr_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wvalid(m_axi_wvalid),
    .m_axi_wready(m_axi_wready),
    .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
    .m_axi_araddr(m_axi_araddr), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rvalid(m_axi_rvalid),
    .m_axi_rready(m_axi_rready)
  );

  always #5 aclk = ~aclk;

  // ---------------- slave configuration (written by the stimulus only)
  int          cfg_aw_dly, cfg_w_dly, cfg_b_dly, cfg_ar_dly, cfg_r_dly;
  bit          cfg_w_early;
  logic [1:0]  cfg_bresp, cfg_rresp;

  // ---------------- register-block slave model
  logic          s_aw_got, s_w_got, s_b_pend, s_bvalid, s_r_pend, s_rvalid;
  int            s_aw_cnt, s_w_cnt, s_b_cnt, s_ar_cnt, s_r_cnt;
  logic [AW-1:0] s_awaddr;
  logic [DW-1:0] s_wdata, s_rdata;
  logic [SW-1:0] s_wstrb;
  logic [1:0]    s_bresp, s_rresp;
  logic [DW-1:0] s_mem [4];
  int            n_aw_hs, n_w_hs, n_ar_hs;

  assign m_axi_awready = m_axi_awvalid && !s_aw_got && (s_aw_cnt >= cfg_aw_dly);
  assign m_axi_wready  = !s_w_got && (cfg_w_early || (m_axi_wvalid && s_w_cnt >= cfg_w_dly));
  assign m_axi_arready = m_axi_arvalid && !s_r_pend && (s_ar_cnt >= cfg_ar_dly);
  assign m_axi_bvalid  = s_bvalid;
  assign m_axi_bresp   = s_bresp;
  assign m_axi_rvalid  = s_rvalid;
  assign m_axi_rdata   = s_rdata;
  assign m_axi_rresp   = s_rresp;

  always @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      s_aw_got <= 1'b0; s_w_got <= 1'b0; s_b_pend <= 1'b0; s_bvalid <= 1'b0;
      s_r_pend <= 1'b0; s_rvalid <= 1'b0;
      s_aw_cnt <= 0; s_w_cnt <= 0; s_b_cnt <= 0; s_ar_cnt <= 0; s_r_cnt <= 0;
      s_awaddr <= '0; s_wdata <= '0; s_wstrb <= '0; s_rdata <= '0;
      s_bresp <= '0; s_rresp <= '0;
      n_aw_hs <= 0; n_w_hs <= 0; n_ar_hs <= 0;
      for (int i = 0; i < 4; i++) s_mem[i] <= '0;
    end else begin
      if (m_axi_awvalid && !s_aw_got) begin
        if (m_axi_awready) begin
          s_aw_got <= 1'b1; s_awaddr <= m_axi_awaddr; s_aw_cnt <= 0; n_aw_hs <= n_aw_hs + 1;
        end else s_aw_cnt <= s_aw_cnt + 1;
      end
      if (m_axi_wvalid && !s_w_got) begin
        if (m_axi_wready) begin
          s_w_got <= 1'b1; s_wdata <= m_axi_wdata; s_wstrb <= m_axi_wstrb; s_w_cnt <= 0;
          n_w_hs <= n_w_hs + 1;
        end else s_w_cnt <= s_w_cnt + 1;
      end
      if (s_aw_got && s_w_got && !s_b_pend) begin
        if (cfg_bresp == 2'b00)
          for (int k = 0; k < 4; k++)
            if (s_wstrb[k]) s_mem[s_awaddr[3:2]][8*k +: 8] <= s_wdata[8*k +: 8];
        s_bresp <= cfg_bresp; s_b_pend <= 1'b1; s_b_cnt <= 0;
        s_aw_got <= 1'b0; s_w_got <= 1'b0;
      end
      if (s_b_pend && !s_bvalid) begin
        if (s_b_cnt >= cfg_b_dly) s_bvalid <= 1'b1;
        else s_b_cnt <= s_b_cnt + 1;
      end
      if (s_bvalid && m_axi_bready) begin
        s_bvalid <= 1'b0; s_b_pend <= 1'b0;
      end
      if (m_axi_arvalid && !s_r_pend) begin
        if (m_axi_arready) begin
          s_r_pend <= 1'b1; s_r_cnt <= 0; s_ar_cnt <= 0; n_ar_hs <= n_ar_hs + 1;
          s_rresp  <= cfg_rresp;
          s_rdata  <= (cfg_rresp != 2'b00) ? 32'hDEADBEEF : s_mem[m_axi_araddr[3:2]];
        end else s_ar_cnt <= s_ar_cnt + 1;
      end
      if (s_r_pend && !s_rvalid) begin
        if (s_r_cnt >= cfg_r_dly) s_rvalid <= 1'b1;
        else s_r_cnt <= s_r_cnt + 1;
      end
      if (s_rvalid && m_axi_rready) begin
        s_rvalid <= 1'b0; s_r_pend <= 1'b0;
      end
    end
  end

  // ---------------- reference model and bookkeeping
  typedef struct packed {
    logic        client;
    logic [1:0]  resp;
    logic [31:0] rdata;
  } exp_t;

  exp_t        exp_q [$];
  logic [31:0] model_mem [4];
  int          m_last;
  int          n_checks, n_fail, n_viol, n_rsp, aw_cyc, w_cyc;
  logic [1:0]  acc;
  logic [31:0] last_rdata;
  logic [1:0]  last_resp;
  logic        p_awv, p_aw_hs, p_wv, p_w_hs, p_arv, p_ar_hs, p_brdy, p_b_hs, p_rrdy, p_r_hs;
  logic [AW-1:0] p_awaddr, p_araddr;
  logic [DW-1:0] p_wdata;
  logic [SW-1:0] p_wstrb;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic clear_model();
    exp_q.delete();
    for (int i = 0; i < 4; i++) model_mem[i] = '0;
    m_last = 1;
  endtask

  // Expected outcome of the command client c is presenting, fixed at its acceptance
  task automatic model_accept(input int c);
    exp_t        e;
    logic [3:0]  a;
    logic [31:0] d;
    logic [3:0]  s;
    int          idx;
    a   = req_addr[c*AW +: AW];
    d   = req_wdata[c*DW +: DW];
    s   = req_wstrb[c*SW +: SW];
    idx = int'(a[3:2]);
    e.client = (c == 1);
    if (req_write[c]) begin
      e.resp  = cfg_bresp;
      e.rdata = '0;
      if (cfg_bresp == 2'b00)
        for (int k = 0; k < 4; k++)
          if (s[k]) model_mem[idx][8*k +: 8] = d[8*k +: 8];
    end else if (cfg_rresp != 2'b00) begin
      e.resp  = cfg_rresp;
      e.rdata = 32'hDEADBEEF;
    end else begin
      e.resp  = 2'b00;
      e.rdata = model_mem[idx];
    end
    exp_q.push_back(e);
    m_last = c;
  endtask

  // One clock: protocol stability checks, response scoreboard, accept sampling
  task automatic cycle();
    exp_t e;
    @(posedge aclk); #1;
    acc = 2'b00;
    if (!aresetn) begin
      p_awv = 0; p_wv = 0; p_arv = 0; p_brdy = 0; p_rrdy = 0;
    end else begin
      if (p_awv && !p_aw_hs && (!m_axi_awvalid || m_axi_awaddr != p_awaddr)) n_viol++;
      if (p_wv && !p_w_hs && (!m_axi_wvalid || m_axi_wdata != p_wdata || m_axi_wstrb != p_wstrb))
        n_viol++;
      if (p_arv && !p_ar_hs && (!m_axi_arvalid || m_axi_araddr != p_araddr)) n_viol++;
      if (p_brdy && !p_b_hs && !m_axi_bready) n_viol++;
      if (p_rrdy && !p_r_hs && !m_axi_rready) n_viol++;
      p_awv = m_axi_awvalid; p_aw_hs = m_axi_awvalid && m_axi_awready; p_awaddr = m_axi_awaddr;
      p_wv  = m_axi_wvalid;  p_w_hs  = m_axi_wvalid && m_axi_wready;
      p_wdata = m_axi_wdata; p_wstrb = m_axi_wstrb;
      p_arv = m_axi_arvalid; p_ar_hs = m_axi_arvalid && m_axi_arready; p_araddr = m_axi_araddr;
      p_brdy = m_axi_bready; p_b_hs = m_axi_bready && m_axi_bvalid;
      p_rrdy = m_axi_rready; p_r_hs = m_axi_rready && m_axi_rvalid;
      if (m_axi_awvalid) aw_cyc++;
      if (m_axi_wvalid)  w_cyc++;
      if (rsp_valid != 2'b00) begin
        n_rsp++;
        last_rdata = rsp_rdata;
        last_resp  = rsp_resp;
        if (exp_q.size() == 0) check("rsp_unexpected", 64'(rsp_valid), 64'(0));
        else begin
          e = exp_q.pop_front();
          check("rsp_client", 64'(rsp_valid), 64'(e.client ? 2'b10 : 2'b01));
          check("rsp_resp",   64'(rsp_resp),  64'(e.resp));
          check("rsp_rdata",  64'(rsp_rdata), 64'(e.rdata));
        end
      end
      acc = req_ready;
    end
  endtask

  task automatic drive(input int c, input bit wr, input logic [3:0] a,
                       input logic [31:0] d, input logic [3:0] s);
    req_write[c]         = wr;
    req_addr[c*AW +: AW] = a;
    req_wdata[c*DW +: DW] = d;
    req_wstrb[c*SW +: SW] = s;
    req_valid[c]         = 1'b1;
  endtask

  task automatic wait_accept(input logic [1:0] mask, input bit drop, output int g);
    bit found;
    found = 0;
    g = -1;
    for (int i = 0; i < 100 && !found; i++) begin
      cycle();
      if ((acc & mask) != 2'b00) begin
        found = 1;
        check("grant_onehot", 64'($countones(acc)), 64'(1));
        g = acc[0] ? 0 : 1;
        model_accept(g);
        if (drop) req_valid[g] = 1'b0;
      end
    end
    if (!found) check("accept_timeout", 64'(0), 64'(1));
  endtask

  task automatic wait_done();
    bit done;
    done = (exp_q.size() == 0);
    for (int i = 0; i < 300 && !done; i++) begin
      cycle();
      done = (exp_q.size() == 0);
    end
    if (!done) check("rsp_timeout", 64'(exp_q.size()), 64'(0));
  endtask

  task automatic op(input int c, input bit wr, input logic [3:0] a,
                    input logic [31:0] d, input logic [3:0] s);
    int g;
    drive(c, wr, a, d, s);
    wait_accept(c == 1 ? 2'b10 : 2'b01, 1'b1, g);
    wait_done();
  endtask

  task automatic zero_cfg();
    cfg_aw_dly = 0; cfg_w_dly = 0; cfg_b_dly = 0; cfg_ar_dly = 0; cfg_r_dly = 0;
    cfg_w_early = 0; cfg_bresp = 2'b00; cfg_rresp = 2'b00;
  endtask

  task automatic apply_reset();
    aresetn = 1'b0;
    req_valid = 2'b00;
    clear_model();
    repeat (3) cycle();
    aresetn = 1'b1;
    cycle();
  endtask

  task automatic check_outputs_zero(input string tag);
    check(tag, 64'({req_ready, rsp_valid, m_axi_awvalid, m_axi_wvalid, m_axi_bready,
                    m_axi_arvalid, m_axi_rready, rsp_resp, m_axi_awaddr, m_axi_wstrb,
                    m_axi_araddr}), 64'(0));
    check({tag, "_data"}, {rsp_rdata, m_axi_wdata}, 64'(0));
  endtask

  initial begin
    int g, g2, a0, w0, r0, ac0, wc0, c, exp_first;
    bit wr;
    n_checks = 0; n_fail = 0; n_viol = 0; n_rsp = 0; aw_cyc = 0; w_cyc = 0;
    req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
    last_rdata = '0; last_resp = '0;
    zero_cfg();
    apply_reset();
    check_outputs_zero("reset_state");

    // Write then cross-client read-back
    a0 = n_aw_hs; w0 = n_w_hs;
    op(0, 1'b1, 4'h4, 32'hA5A5_1234, 4'hF);
    check("t1_aw_hs",  64'(n_aw_hs - a0), 64'(1));
    check("t1_w_hs",   64'(n_w_hs - w0),  64'(1));
    check("t1_awaddr", 64'(s_awaddr),     64'(4'h4));
    check("t1_bresp",  64'(last_resp),    64'(0));
    op(1, 1'b0, 4'h4, 32'h0, 4'h0);
    check("t1_rdata",  64'(last_rdata),   64'(32'hA5A5_1234));

    // Both clients hold reads: grants must alternate starting with client 0
    apply_reset();
    drive(0, 1'b0, 4'h0, 32'h0, 4'h0);
    drive(1, 1'b0, 4'h8, 32'h0, 4'h0);
    for (int k = 0; k < 6; k++) begin
      wait_accept(2'b11, 1'b0, g);
      check("t2_grant", 64'(g), 64'(k % 2));
    end
    req_valid = 2'b00;
    wait_done();

    // Byte-strobe merge
    op(0, 1'b1, 4'hC, 32'h1122_3344, 4'hF);
    op(1, 1'b1, 4'hC, 32'hFFFF_FFFF, 4'h2);
    op(0, 1'b0, 4'hC, 32'h0, 4'h0);
    check("t3_rdata", 64'(last_rdata), 64'(32'h1122_FF44));

    // Stalled slave: late AW, early W, late B
    cfg_aw_dly = 3; cfg_w_early = 1; cfg_b_dly = 5;
    a0 = n_aw_hs; w0 = n_w_hs; r0 = n_rsp; ac0 = aw_cyc; wc0 = w_cyc;
    op(1, 1'b1, 4'h8, 32'h0BAD_F00D, 4'hF);
    repeat (4) cycle();
    check("t4_aw_hs",     64'(n_aw_hs - a0), 64'(1));
    check("t4_w_hs",      64'(n_w_hs - w0),  64'(1));
    check("t4_rsp_count", 64'(n_rsp - r0),   64'(1));
    check("t4_aw_cycles", 64'(aw_cyc - ac0), 64'(4));
    check("t4_w_cycles",  64'(w_cyc - wc0),  64'(1));
    zero_cfg();

    // Slave error on read passes through, then normal traffic resumes
    cfg_rresp = 2'b10;
    r0 = n_rsp;
    op(0, 1'b0, 4'h0, 32'h0, 4'h0);
    check("t5_rdata", 64'(last_rdata), 64'(32'hDEADBEEF));
    check("t5_rresp", 64'(last_resp),  64'(2'b10));
    cfg_rresp = 2'b00;
    op(1, 1'b0, 4'h8, 32'h0, 4'h0);
    check("t5_recover", 64'(n_rsp - r0), 64'(2));

    // Reset asserted while waiting for B
    cfg_b_dly = 10;
    drive(0, 1'b1, 4'h0, 32'h0000_0055, 4'hF);
    wait_accept(2'b01, 1'b1, g);
    for (int i = 0; i < 50 && !m_axi_bready; i++) cycle();
    check("t6_in_wr_resp", 64'(m_axi_bready), 64'(1));
    aresetn = 1'b0;
    #1;
    check_outputs_zero("t6_reset_outputs");
    clear_model();
    repeat (3) cycle();
    check_outputs_zero("t6_reset_hold");
    aresetn = 1'b1;
    zero_cfg();
    cycle();
    drive(0, 1'b0, 4'h4, 32'h0, 4'h0);
    drive(1, 1'b0, 4'hC, 32'h0, 4'h0);
    wait_accept(2'b11, 1'b1, g);
    check("t6_first_grant", 64'(g), 64'(0));
    wait_accept(2'b10, 1'b1, g2);
    wait_done();

    // Randomized traffic with random stalls, errors and simultaneous requests
    for (int it = 0; it < 60; it++) begin
      cfg_aw_dly  = int'($urandom_range(0, 3));
      cfg_w_dly   = int'($urandom_range(0, 3));
      cfg_b_dly   = int'($urandom_range(0, 3));
      cfg_ar_dly  = int'($urandom_range(0, 3));
      cfg_r_dly   = int'($urandom_range(0, 3));
      cfg_w_early = ($urandom_range(0, 1) == 1);
      cfg_bresp   = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      cfg_rresp   = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      if ($urandom_range(0, 2) == 0) begin
        exp_first = (m_last == 0) ? 1 : 0;
        for (int k = 0; k < 2; k++)
          drive(k, ($urandom_range(0, 1) == 1), 4'($urandom_range(0, 3) << 2),
                $urandom, 4'($urandom_range(0, 15)));
        wait_accept(2'b11, 1'b1, g);
        check("rand_first_grant", 64'(g), 64'(exp_first));
        wait_accept(g == 0 ? 2'b10 : 2'b01, 1'b1, g2);
        wait_done();
      end else begin
        c  = int'($urandom_range(0, 1));
        wr = ($urandom_range(0, 1) == 1);
        op(c, wr, 4'($urandom_range(0, 3) << 2), $urandom, 4'($urandom_range(0, 15)));
      end
    end

    // Final read-back of every register against the model
    zero_cfg();
    for (int i = 0; i < 4; i++) op(i % 2, 1'b0, 4'(i << 2), 32'h0, 4'h0);

    repeat (3) cycle();
    check("protocol_violations", 64'(n_viol), 64'(0));
    check("pending_responses",   64'(exp_q.size()), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
